// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C EEPROM arbiter slice: FSM state encoding,
// default device address and the clock/SCL-derived cycle constants.
// -----------------------------------------------------------------------------
package i2c_pkg;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  // 24LCxx-style EEPROM 7-bit device address
  localparam logic [6:0] DEF_DEV_ADDR = 7'h50;

  // System clock and SCL rate, both in kHz
  localparam int CLK_FREQ_KHZ = 32'd50000;
  localparam int I2C_FREQ     = 32'd250;

  // clk cycles per SCL period
  localparam int CYC_PER_SCL  = CLK_FREQ_KHZ / I2C_FREQ;

  // A byte transfer is well under 100 SCL periods; anything longer means the
  // controller gave up on a NACK.
  localparam int DEF_TIMEOUT_CYC = CYC_PER_SCL * 32'd100;

  // EEPROM internal write cycle tWR = 5 ms
  localparam int TWR_US          = 32'd5000;
  localparam int DEF_WR_GAP_CYC  = (CLK_FREQ_KHZ / 32'd1000) * TWR_US;

  // Shared counter width, large enough for both limits above
  localparam int DEF_CNT_W = 32'd20;

  // Last counter value for a limit of `cyc` cycles, truncated to the counter width
  function automatic logic [31:0] last_count(input int cyc);
    logic [31:0] v;
    v = 32'(cyc) - 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin selector. The pick is combinational; the last served
// requester is registered and updated whenever the parent takes a grant.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   valid0_i      requester 0 pending
//   valid1_i      requester 1 pending
//   take_i        parent accepts the current pick this cycle
//   any_o         at least one requester pending
//   sel_o         selected requester index (0 or 1)
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic take_i,
  output logic any_o,
  output logic sel_o
);

  // Reset to 1 so requester 0 wins the first tie
  logic last_grant_q;

  assign any_o = valid0_i | valid1_i;

  // Lone requester wins; on a tie the one not served last wins
  always_comb begin
    sel_o = 1'b0;
    if (valid0_i && valid1_i) begin
      sel_o = ~last_grant_q;
    end else if (valid1_i) begin
      sel_o = 1'b1;
    end else begin
      sel_o = 1'b0;
    end
  end

  // Track the last served requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (take_i) begin
      last_grant_q <= sel_o;
    end else begin
      last_grant_q <= last_grant_q;
    end
  end

endmodule

// File: rtl/i2c_eeprom_arbiter.sv
// -----------------------------------------------------------------------------
// i2c_eeprom_arbiter
// Shares one I2C EEPROM byte-transfer controller between two requesters.
// A request is latched in IDLE, issued with a one-cycle i2c_start, and the
// controller inputs are held until i2c_done or a timeout. After a completed
// write the EEPROM needs its internal write cycle, so the arbiter idles in GAP.
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   reqN_valid/ready           request handshake (ready is a 1-cycle pulse)
//   reqN_addr/wdata/rd         16-bit address, write byte, write-then-read flag
//   rsp0_done, rsp1_done       1-cycle completion pulse per requester
//   rsp_err                    qualifies rspN_done: 1 = timeout
//   busy                       high outside IDLE
//   i2c_start                  1-cycle start pulse to the controller
//   wr_dev, rd_dev             constant control bytes
//   addh, addl, wr_data,
//   rd_flag                    controller transfer fields
//   i2c_done                   controller completion pulse
// -----------------------------------------------------------------------------
module i2c_eeprom_arbiter
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = DEF_DEV_ADDR,
  parameter int         TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int         WR_GAP_CYC  = DEF_WR_GAP_CYC,
  parameter int         CNT_W       = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_addr,
  input  logic [7:0]  req0_wdata,
  input  logic        req0_rd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_addr,
  input  logic [7:0]  req1_wdata,
  input  logic        req1_rd,
  output logic        rsp0_done,
  output logic        rsp1_done,
  output logic        rsp_err,
  output logic        busy,
  output logic        i2c_start,
  output logic [7:0]  wr_dev,
  output logic [7:0]  rd_dev,
  output logic [7:0]  addh,
  output logic [7:0]  addl,
  output logic [7:0]  wr_data,
  output logic        rd_flag,
  input  logic        i2c_done
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(last_count(TIMEOUT_CYC));
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(last_count(WR_GAP_CYC));

  state_e           state_q;
  logic             owner_q;
  logic [CNT_W-1:0] cnt_q;
  logic             req0_ready_q;
  logic             req1_ready_q;
  logic             rsp0_done_q;
  logic             rsp1_done_q;
  logic             rsp_err_q;
  logic             busy_q;
  logic             i2c_start_q;
  logic [7:0]       addh_q;
  logic [7:0]       addl_q;
  logic [7:0]       wr_data_q;
  logic             rd_flag_q;

  logic             any_valid_s;
  logic             sel_s;
  logic             take_s;

  // A grant is only taken from IDLE; valids elsewhere are ignored
  assign take_s = (state_q == ST_IDLE) && any_valid_s;

  rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .take_i   (take_s),
    .any_o    (any_valid_s),
    .sel_o    (sel_s)
  );

  // Arbiter FSM, shared cycle counter and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      cnt_q        <= CNT_ZERO;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp0_done_q  <= 1'b0;
      rsp1_done_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      i2c_start_q  <= 1'b0;
      addh_q       <= 8'h00;
      addl_q       <= 8'h00;
      wr_data_q    <= 8'h00;
      rd_flag_q    <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      i2c_start_q  <= 1'b0;
      rsp0_done_q  <= 1'b0;
      rsp1_done_q  <= 1'b0;
      rsp_err_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (any_valid_s) begin
            // Controller-facing fields change only here
            owner_q      <= sel_s;
            if (sel_s) begin
              addh_q    <= req1_addr[15:8];
              addl_q    <= req1_addr[7:0];
              wr_data_q <= req1_wdata;
              rd_flag_q <= req1_rd;
            end else begin
              addh_q    <= req0_addr[15:8];
              addl_q    <= req0_addr[7:0];
              wr_data_q <= req0_wdata;
              rd_flag_q <= req0_rd;
            end
            // ready/start become visible during the START cycle
            req0_ready_q <= ~sel_s;
            req1_ready_q <= sel_s;
            i2c_start_q  <= 1'b1;
            cnt_q        <= CNT_ZERO;
            busy_q       <= 1'b1;
            state_q      <= ST_START;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        ST_START: begin
          // Counter is zero during the start cycle, so it counts cycles since start
          cnt_q   <= cnt_q + CNT_ONE;
          busy_q  <= 1'b1;
          state_q <= ST_BUSY;
        end

        ST_BUSY: begin
          // Done takes priority over a coincident timeout
          if (i2c_done) begin
            rsp0_done_q <= ~owner_q;
            rsp1_done_q <= owner_q;
            rsp_err_q   <= 1'b0;
            if (rd_flag_q) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= CNT_ZERO;
              busy_q  <= 1'b1;
              state_q <= ST_GAP;
            end
          end else if (cnt_q >= TMO_LAST) begin
            // Controller already dropped back to idle after a NACK
            rsp0_done_q <= ~owner_q;
            rsp1_done_q <= owner_q;
            rsp_err_q   <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end

        ST_GAP: begin
          // EEPROM write cycle; spurious done is ignored here
          if (cnt_q >= GAP_LAST) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cnt_q   <= cnt_q + CNT_ONE;
            busy_q  <= 1'b1;
            state_q <= ST_GAP;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req0_ready = req0_ready_q;
  assign req1_ready = req1_ready_q;
  assign rsp0_done  = rsp0_done_q;
  assign rsp1_done  = rsp1_done_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;
  assign i2c_start  = i2c_start_q;
  assign wr_dev     = {DEV_ADDR, 1'b0};
  assign rd_dev     = {DEV_ADDR, 1'b1};
  assign addh       = addh_q;
  assign addl       = addl_q;
  assign wr_data    = wr_data_q;
  assign rd_flag    = rd_flag_q;

endmodule
